// File: rtl/i2c_read_sequencer_if.sv
// i2c_read_sequencer_if: single-outstanding request/ack bus from the read sequencer to its AXI master.
interface i2c_read_sequencer_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    logic                      seq_axi_wr_req;
    logic                      seq_axi_rd_req;
    logic [AXI_ADDR_WIDTH-1:0] seq_axi_addr;
    logic [AXI_DATA_WIDTH-1:0] seq_axi_wdata;
    logic                      seq_axi_ack;
    logic [AXI_DATA_WIDTH-1:0] seq_axi_rdata;

    modport master (
        output seq_axi_wr_req, seq_axi_rd_req, seq_axi_addr, seq_axi_wdata,
        input  seq_axi_ack, seq_axi_rdata
    );

    modport slave (
        input  seq_axi_wr_req, seq_axi_rd_req, seq_axi_addr, seq_axi_wdata,
        output seq_axi_ack, seq_axi_rdata
    );
endinterface

// File: rtl/i2c_read_sequencer.sv
// i2c_read_sequencer: drives an AXI I2C controller through one register read of 1..16 bytes.
// Defining I2C_RD_SEQ_TIMEOUT_EN bounds SR polling per byte to POLL_LIMIT reads.
module i2c_read_sequencer #(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter logic [15:0] POLL_LIMIT     = 16'hFFFF
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start_pulse,
    input  logic [7:0]           rd_dev_id,
    input  logic [7:0]           rd_reg_addr,
    input  logic [4:0]           rd_len,
    i2c_read_sequencer_if.master seq_axi,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);
    typedef enum logic [3:0] {
        IDLE, CLR_ISR_RD, CLR_ISR_WR, SET_PIRQ, TX_DEVW, TX_ADDR, TX_DEVR, TX_LEN,
        CR_EN, POLL_SR, POLL_GAP, RD_FIFO, CR_DIS, DONE
    } state_t;

    localparam logic [11:0] ISR = 12'h020, CR = 12'h100, SR = 12'h104;
    localparam logic [11:0] TXFIFO = 12'h108, RXFIFO = 12'h10C, RX_PIRQ = 12'h120;

    state_t                    r_state, w_nxt;
    logic                      r_wr_req, r_rd_req, r_rd_valid;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata, w_wdata;
    logic [7:0]                r_rd_data, r_reg;
    logic [6:0]                r_dev;
    logic [4:0]                r_len, r_cnt;
    logic [11:0]               w_addr;
    logic                      w_rd, w_issue, w_ack, w_empty, w_last, w_tmo, w_unused;

    // ack in the pulse cycle itself belongs to no request and is ignored
    assign w_ack   = seq_axi.seq_axi_ack && !r_wr_req && !r_rd_req;
    assign w_empty = seq_axi.seq_axi_rdata[6];
    assign w_last  = r_cnt + 5'd1 == r_len;
    assign w_unused = ^{rd_dev_id[0], POLL_LIMIT};

`ifdef I2C_RD_SEQ_TIMEOUT_EN
    logic [15:0] r_poll;
    logic        r_timeout;
    assign w_tmo       = r_poll + 16'd1 == POLL_LIMIT;
    assign timeout_err = r_timeout;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:     w_nxt = !start_pulse ? IDLE : rd_len == 5'd0 ? DONE : CLR_ISR_RD;
            POLL_SR:  w_nxt = !w_ack ? POLL_SR : !w_empty ? RD_FIFO : w_tmo ? CR_DIS : POLL_GAP;
            POLL_GAP: w_nxt = POLL_SR;
            RD_FIFO:  w_nxt = !w_ack ? RD_FIFO : w_last ? CR_DIS : POLL_SR;
            CR_DIS:   w_nxt = w_ack ? DONE : CR_DIS;
            DONE:     w_nxt = IDLE;
            default:  w_nxt = w_ack ? state_t'(r_state + 4'd1) : r_state;
        endcase
    end

    // request parameters for the state being entered; CR writes are the fallback
    always_comb begin
        w_rd    = 1'b0;
        w_addr  = CR;
        w_wdata = AXI_DATA_WIDTH'(1);
        case (w_nxt)
            CLR_ISR_RD: begin w_rd = 1'b1; w_addr = ISR; end
            CLR_ISR_WR: begin w_addr = ISR; w_wdata = seq_axi.seq_axi_rdata; end
            SET_PIRQ:   begin w_addr = RX_PIRQ; w_wdata = AXI_DATA_WIDTH'(r_len - 5'd1); end
            TX_DEVW:    begin w_addr = TXFIFO; w_wdata = AXI_DATA_WIDTH'({2'b01, r_dev, 1'b0}); end
            TX_ADDR:    begin w_addr = TXFIFO; w_wdata = AXI_DATA_WIDTH'(r_reg); end
            TX_DEVR:    begin w_addr = TXFIFO; w_wdata = AXI_DATA_WIDTH'({2'b01, r_dev, 1'b1}); end
            TX_LEN:     begin w_addr = TXFIFO; w_wdata = AXI_DATA_WIDTH'({5'b10000, r_len}); end
            POLL_SR:    begin w_rd = 1'b1; w_addr = SR; end
            RD_FIFO:    begin w_rd = 1'b1; w_addr = RXFIFO; end
            default:    ;
        endcase
    end

    assign w_issue = w_nxt != r_state && w_nxt != IDLE && w_nxt != POLL_GAP && w_nxt != DONE;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_wr_req   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
            r_dev      <= 7'd0;
            r_reg      <= 8'd0;
            r_len      <= 5'd0;
            r_cnt      <= 5'd0;
`ifdef I2C_RD_SEQ_TIMEOUT_EN
            r_poll     <= 16'd0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_nxt;
            r_wr_req   <= w_issue && !w_rd;
            r_rd_req   <= w_issue && w_rd;
            r_rd_valid <= r_state == RD_FIFO && w_ack;
            if (w_issue) begin
                r_addr  <= AXI_ADDR_WIDTH'(w_addr);
                r_wdata <= w_wdata;
            end
            if (r_state == RD_FIFO && w_ack) begin
                r_rd_data <= seq_axi.seq_axi_rdata[7:0];
                r_cnt     <= r_cnt + 5'd1;
            end
            if (r_state == IDLE && start_pulse) begin
                r_dev <= rd_dev_id[7:1];
                r_reg <= rd_reg_addr;
                r_len <= rd_len;
                r_cnt <= 5'd0;
            end
`ifdef I2C_RD_SEQ_TIMEOUT_EN
            if (r_state == IDLE && start_pulse) begin
                r_poll    <= 16'd0;
                r_timeout <= 1'b0;
            end else if (r_state == RD_FIFO && w_ack) begin
                r_poll <= 16'd0;
            end else if (r_state == POLL_SR && w_ack && w_empty) begin
                r_poll <= r_poll + 16'd1;
                if (w_tmo) r_timeout <= 1'b1;
            end
`endif
        end
    end

    assign seq_axi.seq_axi_wr_req = r_wr_req;
    assign seq_axi.seq_axi_rd_req = r_rd_req;
    assign seq_axi.seq_axi_addr   = r_addr;
    assign seq_axi.seq_axi_wdata  = r_wdata;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_state != IDLE;
    assign done     = r_state == DONE;
endmodule

// File: tb/tb_i2c_read_sequencer.sv
// tb_i2c_read_sequencer: randomized bench with a register-level transaction model and AXI slave responder.
module tb_i2c_read_sequencer;
    localparam int PL = 8;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start_pulse = 1'b0;
    logic [7:0] rd_dev_id = 8'd0;
    logic [7:0] rd_reg_addr = 8'd0;
    logic [4:0] rd_len = 5'd0;
    logic [7:0] rd_data;
    logic       rd_valid, busy, done, timeout_err;

    int checks = 0;
    int failures = 0;

    txn_t        act_q[$];
    txn_t        exp_q[$];
    logic [7:0]  sr_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  want_q[$];
    logic [7:0]  byte_q[$];
    int          emp_q[$];
    logic [31:0] isr_val = 32'h0;

    always #5 aclk = ~aclk;

    i2c_read_sequencer_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

    i2c_read_sequencer #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .POLL_LIMIT(16'(PL))) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .start_pulse(start_pulse),
        .rd_dev_id(rd_dev_id),
        .rd_reg_addr(rd_reg_addr),
        .rd_len(rd_len),
        .seq_axi(bus),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    function automatic void expect_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.wr = wr;
        t.addr = addr;
        t.data = data;
        exp_q.push_back(t);
    endfunction

    // slave: records each request, sometimes raises a stray ack in the pulse cycle, then acks after 1..3 cycles
    task automatic serve();
        txn_t t;
        logic [31:0] rv;
        t.wr = bus.seq_axi_wr_req;
        t.addr = bus.seq_axi_addr;
        t.data = t.wr ? bus.seq_axi_wdata : 32'h0;
        checks++;
        if (bus.seq_axi_wr_req && bus.seq_axi_rd_req) begin
            failures++;
            $display("FAIL req_onehot wr=%0b rd=%0b required exactly one", bus.seq_axi_wr_req, bus.seq_axi_rd_req);
        end
        act_q.push_back(t);
        rv = $urandom;
        case (t.addr)
            32'h020: rv = isr_val;
            32'h104: rv[7:0] = (sr_q.size() > 0) ? sr_q.pop_front() : 8'h40;
            32'h10C: rv[7:0] = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) begin
            bus.seq_axi_ack = 1'b1;
            bus.seq_axi_rdata = $urandom;
            @(posedge aclk);
            #1;
            bus.seq_axi_ack = 1'b0;
        end
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
        if (aresetn) begin
            checks++;
            if (bus.seq_axi_addr !== t.addr || (t.wr && bus.seq_axi_wdata !== t.data)) begin
                failures++;
                $display("FAIL req_hold addr=%h wdata=%h required addr=%h wdata=%h", bus.seq_axi_addr, bus.seq_axi_wdata, t.addr, t.data);
            end
        end
        bus.seq_axi_ack = 1'b1;
        bus.seq_axi_rdata = rv;
        @(posedge aclk);
        #1;
        bus.seq_axi_ack = 1'b0;
        bus.seq_axi_rdata = $urandom;
    endtask

    initial begin
        bus.seq_axi_ack = 1'b0;
        bus.seq_axi_rdata = 32'h0;
        forever begin
            if (bus.seq_axi_wr_req === 1'b1 || bus.seq_axi_rd_req === 1'b1) serve();
            else begin
                @(posedge aclk);
                #1;
            end
        end
    end

    task automatic fill(input int len, input int max_emp);
        emp_q.delete();
        byte_q.delete();
        for (int i = 0; i < len; i++) begin
            emp_q.push_back(int'($urandom_range(0, max_emp)));
            byte_q.push_back(8'($urandom));
        end
    endtask

    task automatic do_txn(input string name, input logic [7:0] dev, input logic [7:0] regad, input logic [4:0] len,
                          input logic [31:0] isr, input bit tmo, input bit extra);
        int tail;
        int dn;
        int n;
        tail = -1;
        dn = 0;
        exp_q.delete();
        sr_q.delete();
        want_q.delete();
        isr_val = isr;
        rx_q = byte_q;
        if (len != 5'd0) begin
            expect_txn(1'b0, 32'h020, 32'h0);
            expect_txn(1'b1, 32'h020, isr);
            expect_txn(1'b1, 32'h120, 32'(len) - 32'd1);
            expect_txn(1'b1, 32'h108, 32'h100 + 32'(dev & 8'hFE));
            expect_txn(1'b1, 32'h108, 32'(regad));
            expect_txn(1'b1, 32'h108, 32'h100 + 32'(dev | 8'h01));
            expect_txn(1'b1, 32'h108, 32'h200 + 32'(len));
            expect_txn(1'b1, 32'h100, 32'h1);
            if (tmo) begin
                for (int i = 0; i < PL; i++) expect_txn(1'b0, 32'h104, 32'h0);
            end else begin
                for (int i = 0; i < int'(len); i++) begin
                    for (int k = 0; k < emp_q[i]; k++) begin
                        expect_txn(1'b0, 32'h104, 32'h0);
                        sr_q.push_back(8'($urandom) | 8'h40);
                    end
                    expect_txn(1'b0, 32'h104, 32'h0);
                    sr_q.push_back(8'($urandom) & 8'hBF);
                    expect_txn(1'b0, 32'h10C, 32'h0);
                    want_q.push_back(byte_q[i]);
                end
            end
            expect_txn(1'b1, 32'h100, 32'h1);
        end
        act_q.delete();
        got_q.delete();
        @(negedge aclk);
        start_pulse = 1'b1;
        rd_dev_id = dev;
        rd_reg_addr = regad;
        rd_len = len;
        for (int c = 0; c < 4000; c++) begin
            @(negedge aclk);
            if (rd_valid) got_q.push_back(rd_data);
            if (done) begin
                dn++;
                if (tail < 0) tail = 4;
            end
            start_pulse = extra && c == 4;
            rd_dev_id = 8'($urandom);
            rd_reg_addr = 8'($urandom);
            rd_len = 5'($urandom);
            if (tail > 0) begin
                tail--;
                if (tail == 0) break;
            end
        end
        start_pulse = 1'b0;
        checks++;
        if (dn != 1) begin
            failures++;
            $display("FAIL %s done_pulses got %0d required 1", name, dn);
        end
        checks++;
        if (act_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s request_count got %0d required %0d", name, act_q.size(), exp_q.size());
        end
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (act_q[i].wr !== exp_q[i].wr || act_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].wr && act_q[i].data !== exp_q[i].data)) begin
                failures++;
                $display("FAIL %s req[%0d] got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h", name, i,
                         act_q[i].wr, act_q[i].addr, act_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (got_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL %s rd_valid_count got %0d required %0d", name, got_q.size(), want_q.size());
        end
        n = (got_q.size() < want_q.size()) ? got_q.size() : want_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== want_q[i]) begin
                failures++;
                $display("FAIL %s rd_data[%0d] got %h required %h", name, i, got_q[i], want_q[i]);
            end
        end
        checks++;
        if (timeout_err !== logic'(tmo)) begin
            failures++;
            $display("FAIL %s timeout_err got %b required %b", name, timeout_err, tmo);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after_done got %b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({busy, done, rd_valid, timeout_err, bus.seq_axi_wr_req, bus.seq_axi_rd_req} !== 6'b0 || rd_data !== 8'h0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b vld=%b tmo=%b wr=%b rd=%b data=%h required all 0",
                     busy, done, rd_valid, timeout_err, bus.seq_axi_wr_req, bus.seq_axi_rd_req, rd_data);
        end
        checks++;
        if (bus.seq_axi_addr !== 32'h0 || bus.seq_axi_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus got addr=%h wdata=%h required 0", bus.seq_axi_addr, bus.seq_axi_wdata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_basic();
        emp_q = '{0};
        byte_q = '{8'h5A};
        do_txn("basic", 8'hB0, 8'h12, 5'd1, 32'h0, 1'b0, 1'b0);
        checks++;
        if (rd_data !== 8'h5A) begin
            failures++;
            $display("FAIL basic_rd_data got %h required 5a", rd_data);
        end
    endtask

    task automatic test_isr_echo();
        fill(2, 1);
        do_txn("isr_echo", 8'($urandom), 8'($urandom), 5'd2, 32'hD0, 1'b0, 1'b0);
        checks++;
        if (act_q.size() < 2 || act_q[1].addr !== 32'h020 || act_q[1].data !== 32'hD0) begin
            failures++;
            $display("FAIL isr_echo write got %h required 000000d0", (act_q.size() < 2) ? 32'hX : act_q[1].data);
        end
    endtask

    task automatic test_multi_byte();
        int n;
        n = 0;
        fill(4, 0);
        emp_q = '{2, 2, 2, 2};
        do_txn("multi", 8'h6C, 8'h3A, 5'd4, $urandom, 1'b0, 1'b0);
        foreach (act_q[i]) if (!act_q[i].wr && act_q[i].addr == 32'h104) n++;
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL multi_sr_reads got %0d required 12", n);
        end
        checks++;
        if (act_q.size() < 3 || act_q[2].data !== 32'h3) begin
            failures++;
            $display("FAIL multi_pirq got %h required 00000003", (act_q.size() < 3) ? 32'hX : act_q[2].data);
        end
    endtask

    task automatic test_random();
        logic [4:0] len;
        for (int r = 0; r < 6; r++) begin
            len = 5'($urandom_range(1, 16));
            fill(int'(len), 3);
            do_txn("random", 8'($urandom), 8'($urandom), len, $urandom, 1'b0, 1'b0);
        end
        len = 5'd16;
        fill(16, 1);
        do_txn("max_len", 8'hFF, 8'hFF, len, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_poll_limit();
`ifdef I2C_RD_SEQ_TIMEOUT_EN
        fill(3, 0);
        do_txn("timeout", 8'($urandom), 8'($urandom), 5'd3, $urandom, 1'b1, 1'b0);
        repeat (5) @(negedge aclk);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_hold got %b required 1", timeout_err);
        end
        fill(0, 0);
        do_txn("timeout_clear", 8'($urandom), 8'($urandom), 5'd0, $urandom, 1'b0, 1'b0);
`else
        fill(1, 0);
        emp_q = '{PL + 2};
        do_txn("unbounded_poll", 8'($urandom), 8'($urandom), 5'd1, $urandom, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset_mid();
        int c;
        sr_q.delete();
        rx_q.delete();
        for (int i = 0; i < 60; i++) sr_q.push_back(8'h40);
        @(negedge aclk);
        start_pulse = 1'b1;
        rd_dev_id = 8'($urandom);
        rd_reg_addr = 8'($urandom);
        rd_len = 5'd3;
        @(negedge aclk);
        start_pulse = 1'b0;
        for (c = 0; c < 2000; c++) begin
            if (bus.seq_axi_rd_req && bus.seq_axi_addr == 32'h104) break;
            @(negedge aclk);
        end
        checks++;
        if (c == 2000) begin
            failures++;
            $display("FAIL reset_mid_wait no SR read within 2000 cycles, required one");
        end
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        checks++;
        if ({busy, done, rd_valid, timeout_err, bus.seq_axi_wr_req, bus.seq_axi_rd_req} !== 6'b0 ||
            bus.seq_axi_addr !== 32'h0 || bus.seq_axi_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs got busy=%b rd=%b addr=%h wdata=%h required all 0",
                     busy, bus.seq_axi_rd_req, bus.seq_axi_addr, bus.seq_axi_wdata);
        end
        repeat (8) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        fill(2, 2);
        do_txn("after_reset", 8'($urandom), 8'($urandom), 5'd2, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill(3, 2);
        do_txn("start_while_busy", 8'($urandom), 8'($urandom), 5'd3, $urandom, 1'b0, 1'b1);
        fill(0, 0);
        do_txn("len_zero", 8'($urandom), 8'($urandom), 5'd0, $urandom, 1'b0, 1'b0);
        fill(1, 1);
        do_txn("after_len_zero", 8'($urandom), 8'($urandom), 5'd1, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_isr_echo();
        test_multi_byte();
        test_random();
        test_poll_limit();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_read_sequencer.md
I2C_READ_SEQUENCER -- requirements
Module: i2c_read_sequencer

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, width of seq_axi_addr.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, width of seq_axi_wdata and seq_axi_rdata.
REQ-003 SHALL have parameter POLL_LIMIT, default 16'hFFFF, maximum SR polls per received byte.
REQ-004 SHALL have port aclk, input, 1, clock; reset aresetn, synchronous, active-low.
REQ-005 SHALL have port aresetn, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start_pulse, input, 1, launches one read transaction.
REQ-007 SHALL have port rd_dev_id, input, 8, 8-bit device ID with bit0 ignored; sampled with start_pulse.
REQ-008 SHALL have port rd_reg_addr, input, 8, target register address; sampled with start_pulse.
REQ-009 SHALL have port rd_len, input, 5, number of bytes to read (1..16); sampled with start_pulse.
REQ-010 SHALL have ports seq_axi_wr_req and seq_axi_rd_req, output, 1 each, single-cycle request pulses to the AXI master.
REQ-011 SHALL have ports seq_axi_addr (output, AXI_ADDR_WIDTH) and seq_axi_wdata (output, AXI_DATA_WIDTH), request address and write data.
REQ-012 SHALL have ports seq_axi_ack (input, 1, completion) and seq_axi_rdata (input, AXI_DATA_WIDTH, read data valid with ack).
REQ-013 SHALL have ports rd_data (output, 8), rd_valid (output, 1), busy (output, 1), done (output, 1 pulse), timeout_err (output, 1).

Function
REQ-014 SHALL use register offsets ISR 0x020, CR 0x100, SR 0x104, TXFIFO 0x108, RXFIFO 0x10C, RX_PIRQ 0x120.
REQ-015 SHALL implement states IDLE, CLR_ISR_RD, CLR_ISR_WR, SET_PIRQ, TX_DEVW, TX_ADDR, TX_DEVR, TX_LEN, CR_EN, POLL_SR, POLL_GAP, RD_FIFO, CR_DIS, DONE.
REQ-016 SHALL leave IDLE only on start_pulse; start_pulse outside IDLE SHALL be ignored; rd_len==0 SHALL go directly to DONE with no bus traffic.
REQ-017 SHALL pulse exactly one of seq_axi_wr_req/seq_axi_rd_req for one cycle on the first cycle of each request state, with addr/wdata valid that cycle and held until ack.
REQ-018 SHALL advance out of a request state only on seq_axi_ack in a cycle after the request pulse; at most one request outstanding.
REQ-019 Sequence: CLR_ISR_RD read ISR; CLR_ISR_WR write ISR with the rdata just read; SET_PIRQ write rd_len-1; TX_DEVW write {dev_id[7:1],0}+0x100; TX_ADDR write rd_reg_addr; TX_DEVR write {dev_id[7:1],1}+0x100; TX_LEN write rd_len+0x200; CR_EN write CR 0x0001.
REQ-020 POLL_SR SHALL read SR; on ack with rdata bit6 (RX_FIFO_EMPTY)=0 go to RD_FIFO, else go to POLL_GAP for one cycle then POLL_SR.
REQ-021 RD_FIFO SHALL read RXFIFO; on ack drive rd_data=rdata[7:0] with rd_valid high exactly one cycle and increment a 5-bit byte counter.
REQ-022 After RD_FIFO, counter==rd_len SHALL go to CR_DIS, otherwise POLL_SR; the poll counter SHALL clear on each byte received.
REQ-023 CR_DIS SHALL write CR 0x0001; on ack go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 timeout_err SHALL clear on accepted start_pulse and hold its value after DONE.

Reset
REQ-026 aresetn low SHALL force IDLE and drive all outputs to 0 on the next edge, including mid-transaction, with no bus clean-up.
REQ-027 Latched dev_id/reg_addr/len, byte counter and poll counter SHALL reset to 0.

Configuration
REQ-028 Macro I2C_RD_SEQ_TIMEOUT_EN defined: when POLL_SR sees RX empty and the poll counter reaches POLL_LIMIT, the block SHALL set timeout_err and go to CR_DIS.
REQ-029 Macro I2C_RD_SEQ_TIMEOUT_EN undefined: polling SHALL be unbounded, the poll counter SHALL be absent, and timeout_err SHALL be tied to 0.

Verification
REQ-030 dev 0xB0, addr 0x12, len 1, SR rdata 0x00, RXFIFO 0x5A -> writes TXFIFO 0x1B0, 0x12, 0x1B1, 0x201; one rd_valid with 0x5A; CR 0x0001; done.
REQ-031 len 4, SR shows 0x40 twice before each byte -> 12 SR reads, 4 rd_valid pulses in order, SET_PIRQ wdata 0x3.
REQ-032 ISR read returns 0xD0 -> next write to 0x020 carries 0xD0.
REQ-033 TIMEOUT_EN, POLL_LIMIT 8, SR always 0x40 -> 8 SR reads, timeout_err=1, CR 0x0001 written, done pulses, no rd_valid.
REQ-034 aresetn low during POLL_SR, then start_pulse -> busy 0 after reset; new transaction begins at ISR read.
REQ-035 start_pulse while busy, and rd_len 0 from IDLE -> first ignored; second gives done with no requests.
